// File: rtl/mc_resp_model_pkg.sv
// Shared encodings for the mc_rq_*/mc_rs_* memory-controller interface and
// the request classification used by the responder model.
package mc_resp_model_pkg;

  localparam logic [2:0] MC_RQ_RD      = 3'd1;
  localparam logic [2:0] MC_RQ_WR      = 3'd2;
  localparam logic [2:0] MC_RS_RD_DATA = 3'd2;
  localparam logic [2:0] MC_RS_WR_CMP  = 3'd3;
  localparam logic [1:0] MC_SIZE_8B    = 2'd3;

  localparam int MC_RTNCTL_W_DEF = 32;
  localparam int TS_W            = 8;

  typedef enum logic [1:0] {
    K_RD    = 2'd0,
    K_WR    = 2'd1,
    K_BAD   = 2'd2,
    K_FLUSH = 2'd3
  } rq_kind_e;

  // Flush wins over cmd; anything not an 8 B RD/WR becomes a dummy completion.
  function automatic rq_kind_e classify(input logic flush, input logic [2:0] cmd,
                                        input logic [1:0] size);
    if (flush)                    return K_FLUSH;
    else if (size != MC_SIZE_8B)  return K_BAD;
    else if (cmd == MC_RQ_RD)     return K_RD;
    else if (cmd == MC_RQ_WR)     return K_WR;
    else                          return K_BAD;
  endfunction

endpackage

// File: rtl/mc_resp_model_fifo.sv
// Synchronous in-order request FIFO with occupancy count, full and empty.
module mc_rq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mc_resp_model.sv
// Memory-controller responder: in-order request FIFO, fixed minimum latency,
// local 64-bit backing store, single response register with hold on stall.
module mc_resp_model
  import mc_resp_model_pkg::*;
#(
  parameter int MC_RTNCTL_WIDTH = MC_RTNCTL_W_DEF,
  parameter int MEM_AW          = 10,
  parameter int RQ_DEPTH        = 8,
  parameter int LATENCY         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mc_rq_vld,
  input  logic [2:0]                 mc_rq_cmd,
  input  logic [3:0]                 mc_rq_scmd,
  input  logic [47:0]                mc_rq_vadr,
  input  logic [1:0]                 mc_rq_size,
  input  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  input  logic [63:0]                mc_rq_data,
  input  logic                       mc_rq_flush,
  output logic                       mc_rq_stall,
  output logic                       mc_rs_vld,
  output logic [2:0]                 mc_rs_cmd,
  output logic [3:0]                 mc_rs_scmd,
  output logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  output logic [63:0]                mc_rs_data,
  input  logic                       mc_rs_stall,
  output logic                       err_ovf,
  output logic                       err_cmd
);
  localparam int CNT_W = $clog2(RQ_DEPTH) + 1;

  typedef struct packed {
    rq_kind_e                   kind;
    logic [MEM_AW-1:0]          adr;
    logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
    logic [63:0]                data;
    logic [TS_W-1:0]            ts;
  } rq_ent_t;

  rq_ent_t                    wr_ent, hd_ent;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic                       full, empty, push, pop, rs_free;
  logic [TS_W-1:0]            ts_q, age;
  logic [63:0]                mem_q [2**MEM_AW];

  logic                       rs_vld_q, rs_vld_d;
  logic [2:0]                 rs_cmd_q, rs_cmd_d;
  logic [MC_RTNCTL_WIDTH-1:0] rs_rtnctl_q, rs_rtnctl_d;
  logic [63:0]                rs_data_q, rs_data_d;
  logic                       rq_stall_q, rq_stall_d;
  logic                       err_ovf_q, err_ovf_d, err_cmd_q, err_cmd_d;

  logic unused_ok;
  assign unused_ok = ^{mc_rq_scmd, mc_rq_vadr[47:MEM_AW+3], mc_rq_vadr[2:0]};

  assign wr_ent = '{kind:   classify(mc_rq_flush, mc_rq_cmd, mc_rq_size),
                    adr:    mc_rq_vadr[MEM_AW+2:3],
                    rtnctl: mc_rq_rtnctl,
                    data:   mc_rq_data,
                    ts:     ts_q};

  assign push    = mc_rq_vld && !full;
  assign rs_free = !rs_vld_q || !mc_rs_stall;
  // Modular age; a head older than 2**TS_W cycles at worst waits a few extra.
  assign age     = ts_q - hd_ent.ts;
  assign pop     = !empty && rs_free && (age >= TS_W'(LATENCY - 1));
  assign cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);

  mc_rq_fifo #(.W($bits(rq_ent_t)), .DEPTH(RQ_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_ent),
    .rdata_o (hd_ent),
    .count_o (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    rs_vld_d    = rs_vld_q;
    rs_cmd_d    = rs_cmd_q;
    rs_rtnctl_d = rs_rtnctl_q;
    rs_data_d   = rs_data_q;
    if (pop) begin
      rs_rtnctl_d = hd_ent.rtnctl;
      case (hd_ent.kind)
        K_RD: begin
          rs_vld_d  = 1'b1;
          rs_cmd_d  = MC_RS_RD_DATA;
          rs_data_d = mem_q[hd_ent.adr];
        end
        K_FLUSH: rs_vld_d = 1'b0;
        default: begin
          rs_vld_d  = 1'b1;
          rs_cmd_d  = MC_RS_WR_CMP;
          rs_data_d = '0;
        end
      endcase
    end else if (rs_free) begin
      rs_vld_d = 1'b0;
    end
    rq_stall_d = (cnt_nxt >= CNT_W'(RQ_DEPTH - 2));
    err_ovf_d  = err_ovf_q || (mc_rq_vld && full);
    err_cmd_d  = err_cmd_q || (push && wr_ent.kind == K_BAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q        <= '0;
      rs_vld_q    <= 1'b0;
      rs_cmd_q    <= '0;
      rs_rtnctl_q <= '0;
      rs_data_q   <= '0;
      rq_stall_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_cmd_q   <= 1'b0;
    end else begin
      ts_q        <= ts_q + 8'd1;
      rs_vld_q    <= rs_vld_d;
      rs_cmd_q    <= rs_cmd_d;
      rs_rtnctl_q <= rs_rtnctl_d;
      rs_data_q   <= rs_data_d;
      rq_stall_q  <= rq_stall_d;
      err_ovf_q   <= err_ovf_d;
      err_cmd_q   <= err_cmd_d;
    end
  end

  // Writes commit at issue so a later read in FIFO order sees the new data.
  always_ff @(posedge clk) begin
    if (pop && hd_ent.kind == K_WR) mem_q[hd_ent.adr] <= hd_ent.data;
  end

  assign mc_rq_stall  = rq_stall_q;
  assign mc_rs_vld    = rs_vld_q;
  assign mc_rs_cmd    = rs_cmd_q;
  assign mc_rs_scmd   = 4'd0;
  assign mc_rs_rtnctl = rs_rtnctl_q;
  assign mc_rs_data   = rs_data_q;
  assign err_ovf      = err_ovf_q;
  assign err_cmd      = err_cmd_q;

endmodule

// File: tb/tb_mc_resp_model.sv
// Directed bench for mc_resp_model: latency, ordering, stall hold, overflow,
// unsupported commands, flush and asynchronous reset.
module tb_mc_resp_model;
  localparam logic [2:0]  RQ_RD = 3'd1, RQ_WR = 3'd2;
  localparam logic [2:0]  RS_RD = 3'd2, RS_WR = 3'd3;
  localparam logic [63:0] D0    = 64'hDEADBEEF_01234567;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        mc_rq_vld = 1'b0, mc_rq_flush = 1'b0, mc_rs_stall = 1'b0;
  logic [2:0]  mc_rq_cmd = '0;
  logic [3:0]  mc_rq_scmd = '0;
  logic [47:0] mc_rq_vadr = '0;
  logic [1:0]  mc_rq_size = 2'd3;
  logic [31:0] mc_rq_rtnctl = '0;
  logic [63:0] mc_rq_data = '0;
  logic        mc_rq_stall, mc_rs_vld, err_ovf, err_cmd;
  logic [2:0]  mc_rs_cmd;
  logic [3:0]  mc_rs_scmd;
  logic [31:0] mc_rs_rtnctl;
  logic [63:0] mc_rs_data;

  int errs = 0, checks = 0;

  mc_resp_model dut (
    .clk(clk), .rst_n(rst_n),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall),
    .err_ovf(err_ovf), .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rq(input logic [2:0] c, input logic [47:0] a, input logic [31:0] r,
                          input logic [63:0] d, input logic f);
    mc_rq_vld = 1'b1; mc_rq_cmd = c; mc_rq_vadr = a; mc_rq_rtnctl = r;
    mc_rq_data = d; mc_rq_flush = f; mc_rq_size = 2'd3; mc_rq_scmd = 4'd0;
  endtask

  task automatic idle_rq;
    mc_rq_vld = 1'b0; mc_rq_flush = 1'b0;
  endtask

  task automatic test_reset;
    logic [106:0] got;
    rst_n = 1'b0;
    tick; tick;
    got = {mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data, err_ovf, err_cmd};
    checks++;
    if (got !== '0) begin errs++; $display("FAIL reset_outputs: got %h exp 0", got); end
    rst_n = 1'b1;
    tick;
    checks++;
    if ({mc_rs_vld, mc_rq_stall} !== 2'b00) begin
      errs++; $display("FAIL reset_release: got %b exp 00", {mc_rs_vld, mc_rq_stall});
    end
  endtask

  task automatic test_rw;
    logic [99:0] got;
    drive_rq(RQ_WR, 48'h40, 32'd5, D0, 1'b0);             tick;
    drive_rq(RQ_RD, 48'h40, 32'd6, 64'd0, 1'b0);          tick;
    drive_rq(RQ_RD, 48'h2047, 32'd7, 64'd0, 1'b0);        tick;  // aliases to 0x40
    idle_rq;
    checks++;
    if (mc_rs_vld !== 1'b0) begin errs++; $display("FAIL rw_early: got %b exp 0", mc_rs_vld); end
    tick;
    got = {mc_rs_vld, mc_rs_cmd, mc_rs_rtnctl, mc_rs_data};
    checks++;
    if (got !== {1'b1, RS_WR, 32'd5, 64'd0}) begin
      errs++; $display("FAIL rw_wrcmp: got %h exp %h", got, {1'b1, RS_WR, 32'd5, 64'd0});
    end
    checks++;
    if (mc_rs_scmd !== 4'd0) begin errs++; $display("FAIL rw_scmd: got %h exp 0", mc_rs_scmd); end
    tick;
    got = {mc_rs_vld, mc_rs_cmd, mc_rs_rtnctl, mc_rs_data};
    checks++;
    if (got !== {1'b1, RS_RD, 32'd6, D0}) begin
      errs++; $display("FAIL rw_rddata: got %h exp %h", got, {1'b1, RS_RD, 32'd6, D0});
    end
    tick;
    got = {mc_rs_vld, mc_rs_cmd, mc_rs_rtnctl, mc_rs_data};
    checks++;
    if (got !== {1'b1, RS_RD, 32'd7, D0}) begin
      errs++; $display("FAIL rw_alias: got %h exp %h", got, {1'b1, RS_RD, 32'd7, D0});
    end
    tick;
    checks++;
    if (mc_rs_vld !== 1'b0) begin errs++; $display("FAIL rw_idle: got %b exp 0", mc_rs_vld); end
  endtask

  task automatic test_back_to_back;
    logic stall_seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      checks++;
      if (mc_rs_vld !== (c >= 4 && c < 12)) begin
        errs++; $display("FAIL b2b_vld c=%0d: got %b exp %b", c, mc_rs_vld, (c >= 4 && c < 12));
      end
      if (c >= 4 && c < 12) begin
        checks++;
        if ({mc_rs_cmd, mc_rs_rtnctl, mc_rs_data} !== {RS_RD, 32'(c - 4), D0}) begin
          errs++; $display("FAIL b2b_resp c=%0d: got %0d/%0d exp %0d/%0d", c,
                           mc_rs_cmd, mc_rs_rtnctl, RS_RD, c - 4);
        end
      end
      stall_seen |= mc_rq_stall;
      if (c < 8) drive_rq(RQ_RD, 48'h40, 32'(c), 64'd0, 1'b0);
      else idle_rq;
      tick;
    end
    checks++;
    if (stall_seen !== 1'b0) begin errs++; $display("FAIL b2b_rqstall: got 1 exp 0"); end
  endtask

  task automatic test_unsupported;
    logic [99:0] got;
    for (int c = 0; c < 10; c++) begin
      got = {mc_rs_vld, mc_rs_cmd, mc_rs_rtnctl, mc_rs_data};
      if (c == 0) begin
        checks++;
        if (err_cmd !== 1'b0) begin errs++; $display("FAIL bad_errcmd_pre: got %b exp 0", err_cmd); end
      end
      if (c == 1) begin
        checks++;
        if (err_cmd !== 1'b1) begin errs++; $display("FAIL bad_errcmd: got %b exp 1", err_cmd); end
      end
      if (c == 4) begin
        checks++;
        if (got !== {1'b1, RS_WR, 32'd9, 64'd0}) begin
          errs++; $display("FAIL bad_wrcmp: got %h exp %h", got, {1'b1, RS_WR, 32'd9, 64'd0});
        end
      end else if (c == 6) begin
        checks++;
        if (got !== {1'b1, RS_RD, 32'd10, D0}) begin
          errs++; $display("FAIL bad_rd_after_flush: got %h exp %h", got, {1'b1, RS_RD, 32'd10, D0});
        end
      end else begin
        checks++;
        if (mc_rs_vld !== 1'b0) begin errs++; $display("FAIL bad_novld c=%0d: got 1 exp 0", c); end
      end
      case (c)
        0: drive_rq(3'd5, 48'h40, 32'd9, 64'h1111_2222_3333_4444, 1'b0);
        1: drive_rq(3'd0, 48'h0, 32'd77, 64'd0, 1'b1);
        2: drive_rq(RQ_RD, 48'h40, 32'd10, 64'd0, 1'b0);
        default: idle_rq;
      endcase
      tick;
    end
  endtask

  task automatic test_stall;
    int sent = 0, rcvd = 0, first_stall_c = -1;
    for (int c = 0; c < 60; c++) begin
      if (mc_rq_stall && first_stall_c < 0) first_stall_c = c;
      mc_rs_stall = (c < 16);
      if (mc_rs_vld && mc_rs_stall) begin
        checks++;
        if ({mc_rs_cmd, mc_rs_rtnctl, mc_rs_data} !== {RS_RD, 32'd100, D0}) begin
          errs++; $display("FAIL stall_hold c=%0d: got %0d/%0d exp %0d/100", c,
                           mc_rs_cmd, mc_rs_rtnctl, RS_RD);
        end
      end
      if (mc_rs_vld && !mc_rs_stall) begin
        checks++;
        if (mc_rs_rtnctl !== 32'(100 + rcvd)) begin
          errs++; $display("FAIL stall_order: got %0d exp %0d", mc_rs_rtnctl, 100 + rcvd);
        end
        rcvd++;
      end
      if (sent < 10 && !mc_rq_stall) begin
        drive_rq(RQ_RD, 48'h40, 32'(100 + sent), 64'd0, 1'b0);
        sent++;
      end else idle_rq;
      tick;
    end
    checks++;
    if (first_stall_c != 7) begin errs++; $display("FAIL stall_rise: got cycle %0d exp 7", first_stall_c); end
    checks++;
    if (err_ovf !== 1'b0) begin errs++; $display("FAIL stall_ovf: got %b exp 0", err_ovf); end
    checks++;
    if (rcvd != 10) begin errs++; $display("FAIL stall_drain: got %0d exp 10", rcvd); end
  endtask

  task automatic test_overflow;
    int rcvd = 0;
    for (int c = 0; c < 50; c++) begin
      mc_rs_stall = (c < 20);
      if (c == 12) begin
        checks++;
        if (err_ovf !== 1'b0) begin errs++; $display("FAIL ovf_pre: got %b exp 0", err_ovf); end
      end
      if (c == 13 || c == 49) begin
        checks++;
        if (err_ovf !== 1'b1) begin errs++; $display("FAIL ovf_set c=%0d: got %b exp 1", c, err_ovf); end
      end
      if (mc_rs_vld && !mc_rs_stall) begin
        checks++;
        if (mc_rs_rtnctl !== 32'(200 + rcvd)) begin
          errs++; $display("FAIL ovf_order: got %0d exp %0d", mc_rs_rtnctl, 200 + rcvd);
        end
        rcvd++;
      end
      if (c == 0) drive_rq(RQ_RD, 48'h40, 32'd200, 64'd0, 1'b0);
      else if (c >= 4 && c <= 12) drive_rq(RQ_RD, 48'h40, 32'(200 + c - 3), 64'd0, 1'b0);
      else idle_rq;
      tick;
    end
    checks++;
    if (rcvd != 9) begin errs++; $display("FAIL ovf_count: got %0d exp 9", rcvd); end
  endtask

  task automatic test_reset_mid;
    logic [106:0] got;
    logic stale = 1'b0;
    mc_rs_stall = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive_rq(RQ_RD, 48'h40, 32'(300 + c), 64'd0, 1'b0);
      else idle_rq;
      tick;
    end
    checks++;
    if (mc_rs_vld !== 1'b1) begin errs++; $display("FAIL rstmid_pre: got %b exp 1", mc_rs_vld); end
    #2 rst_n = 1'b0;
    #1;
    got = {mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data, err_ovf, err_cmd};
    checks++;
    if (got !== '0) begin errs++; $display("FAIL rstmid_async: got %h exp 0", got); end
    tick;
    rst_n = 1'b1;
    mc_rs_stall = 1'b0;
    for (int c = 0; c < 12; c++) begin
      stale |= mc_rs_vld | mc_rq_stall;
      tick;
    end
    checks++;
    if (stale !== 1'b0) begin errs++; $display("FAIL rstmid_stale: got 1 exp 0"); end
  endtask

  initial begin
    test_reset;
    test_rw;
    test_back_to_back;
    test_unsupported;
    test_stall;
    test_overflow;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
